// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: shared types for the binary32 multiplier core and exception_mult.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IEEE_near,
        IEEE_zero,
        IEEE_pinf,
        IEEE_ninf,
        near_up,
        away_zero
    } round_values;

    localparam int EXP_BIAS = 127;
    localparam int EXP_INF  = 255;

    // S1 -> S2: unpacked sign/exponent and the full 48-bit significand product
    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic               sign;
        logic signed [9:0]  exp;
        logic [47:0]        prod;
    } s1_t;

    // S2 -> S3: normalized 23-bit mantissa with guard and sticky
    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic               sign;
        logic signed [9:0]  exp;
        logic [22:0]        mant;
        logic               g;
        logic               s;
    } s2_t;

endpackage

// File: rtl/fp_round.sv
// fp_round: combinational rounding increment and mantissa add for one mode.
module fp_round
    import fp_mult_pkg::*;
#(
    parameter round_values mode = IEEE_near
) (
    input  logic        sign,
    input  logic [22:0] mant,
    input  logic        g,
    input  logic        s,
    output logic        inc,
    output logic [22:0] mant_rnd,
    output logic        carry
);

    // pick the increment from guard/sticky according to the rounding mode
    always_comb begin
        inc = 1'b0;
        case (mode)
            IEEE_near: inc = g & (s | mant[0]);
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = ~sign & (g | s);
            IEEE_ninf: inc = sign & (g | s);
            near_up:   inc = g;
            away_zero: inc = g | s;
            default:   inc = 1'b0;
        endcase
    end

    // carry out means the mantissa wrapped to zero and the exponent must bump
    assign {carry, mant_rnd} = {1'b0, mant} + {23'd0, inc};

endmodule

// File: rtl/fp_mult_core.sv
// fp_mult_core: 3-stage binary32 multiplier datapath (unpack/multiply,
// normalize, round) with valid/ready flow control. Special operands are not
// classified here; exception_mult consumes a_q/b_q/z_calc and the flags.
// Optional macro FP_MULT_CORE_PERF_EN adds saturating op/inexact counters.
module fp_mult_core
    import fp_mult_pkg::*;
#(
    parameter round_values round = IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic [31:0] z_calc,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
`ifdef FP_MULT_CORE_PERF_EN
    ,
    output logic [31:0] op_cnt,
    output logic [31:0] inexact_cnt
`endif
);

    localparam int STAGES = 3;

    logic [STAGES:1]   vld_pipe;
    logic              advance;
    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic              inc, carry;
    logic [22:0]       mant_rnd;
    logic signed [9:0] exp_f;

    // whole pipeline moves together; an empty or draining output frees it
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    // S1: sign, biased exponent sum and significand product (hidden bit forced)
    always_comb begin
        s1_d      = '0;
        s1_d.a    = a;
        s1_d.b    = b;
        s1_d.sign = a[31] ^ b[31];
        s1_d.exp  = 10'({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(EXP_BIAS));
        s1_d.prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    end

    // S2: normalize the product to 1.m, splitting off guard and sticky
    always_comb begin
        s2_d      = '0;
        s2_d.a    = s1_q.a;
        s2_d.b    = s1_q.b;
        s2_d.sign = s1_q.sign;
        if (s1_q.prod[47]) begin
            s2_d.mant = s1_q.prod[46:24];
            s2_d.g    = s1_q.prod[23];
            s2_d.s    = |s1_q.prod[22:0];
            s2_d.exp  = s1_q.exp + 10'sd1;
        end else begin
            s2_d.mant = s1_q.prod[45:23];
            s2_d.g    = s1_q.prod[22];
            s2_d.s    = |s1_q.prod[21:0];
            s2_d.exp  = s1_q.exp;
        end
    end

    fp_round #(.mode(round)) u_round (
        .sign     (s2_q.sign),
        .mant     (s2_q.mant),
        .g        (s2_q.g),
        .s        (s2_q.s),
        .inc      (inc),
        .mant_rnd (mant_rnd),
        .carry    (carry)
    );

    assign exp_f = s2_q.exp + $signed({9'd0, carry});

    // stage registers and valid shift register, all gated by advance
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            z_calc    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (advance) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            a_q       <= s2_q.a;
            b_q       <= s2_q.b;
            z_calc    <= {s2_q.sign, exp_f[7:0], mant_rnd};
            overflow  <= exp_f >= $signed(10'(EXP_INF));
            underflow <= exp_f <= 10'sd0;
            inexact   <= s2_q.g | s2_q.s;
        end
    end

`ifdef FP_MULT_CORE_PERF_EN
    // saturating transfer counters
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt      <= '0;
            inexact_cnt <= '0;
        end else if (out_valid & out_ready) begin
            if (op_cnt != '1)
                op_cnt <= op_cnt + 32'd1;
            if (inexact && inexact_cnt != '1)
                inexact_cnt <= inexact_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_core.sv
// tb_fp_mult_core: one core per rounding mode, shared stimulus, checked
// against an arithmetic reference model through a scoreboard queue.
module tb_fp_mult_core;
    import fp_mult_pkg::*;

    localparam int NM = 6;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [31:0] a, b;
    logic [NM-1:0] in_ready, out_valid, overflow, underflow, inexact;
    logic [NM-1:0][31:0] a_q, b_q, z_calc;
`ifdef FP_MULT_CORE_PERF_EN
    logic [NM-1:0][31:0] op_cnt, inexact_cnt;
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < NM; k++) begin : g_dut
        fp_mult_core #(.round(round_values'(k))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[k]),
            .a         (a),
            .b         (b),
            .out_valid (out_valid[k]),
            .out_ready (out_ready),
            .a_q       (a_q[k]),
            .b_q       (b_q[k]),
            .z_calc    (z_calc[k]),
            .overflow  (overflow[k]),
            .underflow (underflow[k]),
            .inexact   (inexact[k])
`ifdef FP_MULT_CORE_PERF_EN
            ,
            .op_cnt      (op_cnt[k]),
            .inexact_cnt (inexact_cnt[k])
`endif
        );
    end

    typedef struct packed {
        logic [31:0]         a;
        logic [31:0]         b;
        logic [NM-1:0][31:0] z;
        logic [NM-1:0]       o;
        logic [NM-1:0]       u;
        logic                x;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0, n_out = 0, lat, n0;
    logic acc_flag = 1'b0, prev_stall = 1'b0;
    logic [NM-1:0][31:0] prev_z;
    logic [31:0] ops_a[8], ops_b[8];

    // value-level model: exact product, remainder against the half ulp
    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib);
        exp_t e;
        longint unsigned ma, mb, p, qt, rem, half, m;
        int ex, e2, sh;
        logic sg;
        bit inc;
        e = '0;
        e.a = ia;
        e.b = ib;
        sg = ia[31] ^ ib[31];
        ma = {1'b1, ia[22:0]};
        mb = {1'b1, ib[22:0]};
        p = ma * mb;
        ex = int'(ia[30:23]) + int'(ib[30:23]) - 127;
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        if (sh == 24) ex++;
        qt = p >> sh;
        rem = p - (qt << sh);
        half = 64'd1 << (sh - 1);
        e.x = (rem != 0);
        for (int k = 0; k < NM; k++) begin
            case (k)
                0: inc = (rem > half) || (rem == half && qt[0]);
                1: inc = 1'b0;
                2: inc = !sg && rem != 0;
                3: inc = sg && rem != 0;
                4: inc = rem >= half;
                default: inc = rem != 0;
            endcase
            m = (qt & 64'h7FFFFF) + 64'(inc);
            e2 = ex;
            if (m == 64'h800000) begin
                m = 0;
                e2 = ex + 1;
            end
            e.o[k] = (e2 >= 255);
            e.u[k] = (e2 <= 0);
            e.z[k] = {sg, e2[7:0], m[22:0]};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one cycle: sample at negedge (scoreboard, hold, stall), then edge + 1
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        acc_flag = 1'b0;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'h3F);
                for (int k = 0; k < NM; k++) check("hold_z", 64'(z_calc[k]), 64'(prev_z[k]));
            end
            if (out_valid[0] && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid[0] && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("spurious_out", {63'd0, out_valid[0]}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("a_q", 64'(a_q[0]), 64'(e.a));
                    check("b_q", 64'(b_q[0]), 64'(e.b));
                    check("inexact", 64'(inexact), e.x ? 64'h3F : 64'h0);
                    for (int k = 0; k < NM; k++) begin
                        check("z_calc", 64'(z_calc[k]), 64'(e.z[k]));
                        check("overflow", 64'(overflow[k]), 64'(e.o[k]));
                        check("underflow", 64'(underflow[k]), 64'(e.u[k]));
                    end
                end
            end
            if (in_valid && in_ready[0]) begin
                q.push_back(model(a, b));
                acc_cyc = cyc;
                acc_flag = 1'b1;
            end
            prev_stall = out_valid[0] && !out_ready;
            prev_z = z_calc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        int n;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        n = 0;
        acc_flag = 1'b0;
        while (!acc_flag && n < 20) begin
            step();
            n++;
        end
        check("issue_accept", {63'd0, acc_flag}, 64'd1);
        in_valid = 1'b0;
    endtask

    // issue with out_ready low so the result is held for direct inspection;
    // lat counts cycles from the accept cycle to the first cycle with out_valid
    task automatic directed(input logic [31:0] ia, input logic [31:0] ib);
        int n;
        out_ready = 1'b0;
        issue(ia, ib);
        n = 0;
        while (!out_valid[0] && n < 20) begin
            step();
            n++;
        end
        lat = cyc - acc_cyc + 1;
        check("latency", 64'(lat), 64'd3);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a_q", 64'(a_q[0]), 64'd0);
        check("rst_b_q", 64'(b_q[0]), 64'd0);
        check("rst_z", 64'(z_calc[0]), 64'd0);
        check("rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
        rst = 1'b0;
        step();

        directed(32'h3FC00000, 32'h40000000);
        check("t1_z", 64'(z_calc[0]), 64'h40400000);
        check("t1_flags", 64'({overflow[0], underflow[0], inexact[0]}), 64'd0);
        release_out();

        directed(32'h3F800001, 32'h3F800001);
        check("t2_near", 64'(z_calc[0]), 64'h3F800002);
        check("t2_zero", 64'(z_calc[1]), 64'h3F800002);
        check("t2_pinf", 64'(z_calc[2]), 64'h3F800003);
        check("t2_inexact", 64'(inexact[0]), 64'd1);
        release_out();

        directed(32'h7F000000, 32'h7F000000);
        check("t3_ovf", 64'(overflow[0]), 64'd1);
        check("t3_unf", 64'(underflow[0]), 64'd0);
        release_out();

        directed(32'h00800000, 32'h00800000);
        check("t4_unf", 64'(underflow[0]), 64'd1);
        check("t4_ovf", 64'(overflow[0]), 64'd0);
        release_out();

        directed(32'h3FFFFFFF, 32'h3FFFFFFF);
        release_out();
        directed(32'hBF800001, 32'h3F800001);
        release_out();

        // 8 back-to-back ops with a 4-cycle downstream stall mid-stream
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = $urandom;
            ops_b[i] = $urandom;
        end
        n0 = n_out;
        begin
            int sent = 0;
            for (int c = 0; c < 60; c++) begin
                in_valid = (sent < 8);
                if (sent < 8) begin
                    a = ops_a[sent];
                    b = ops_b[sent];
                end
                out_ready = !(c >= 4 && c < 8);
                step();
                if (acc_flag) sent++;
                if (sent == 8 && q.size() == 0) break;
            end
            in_valid = 1'b0;
            check("burst_sent", 64'(sent), 64'd8);
        end
        check("burst_outs", 64'(n_out - n0), 64'd8);
        check("burst_drained", 64'(q.size()), 64'd0);

        // reset with three ops in flight
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        n0 = n_out;
        repeat (6) step();
        check("midrst_no_out", 64'(n_out - n0), 64'd0);
        directed(32'h40400000, 32'h40400000);
        check("post_rst_z", 64'(z_calc[0]), 64'h41100000);
        release_out();

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = $urandom;
            b = $urandom;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        check("random_drained", 64'(q.size()), 64'd0);

`ifdef FP_MULT_CORE_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt_rst_op", 64'(op_cnt[0]), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 3) issue(32'h3F800001, 32'h3F800001);
            else issue(32'h3FC00000, 32'h40000000);
        end
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        check("op_cnt", 64'(op_cnt[0]), 64'd5);
        check("inexact_cnt", 64'(inexact_cnt[0]), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("op_cnt_clr", 64'(op_cnt[0]), 64'd0);
        check("inexact_cnt_clr", 64'(inexact_cnt[0]), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
